// File: rtl/pack_tx_sched_pkg.sv
// pack_tx_sched_pkg: shared constants, FSM state encoding and payload CRC for pack_tx_sched.
// CRC16 is polynomial 0x1021, MSB-first, no reflection, no final XOR.
package pack_tx_sched_pkg;
    localparam logic [7:0]  START_SYM = 8'h3C;
    localparam int          PAYLOAD_W = 1024;
    localparam int          PKT_W     = 1048;
    localparam int          PKT_BYTES = 131;
    localparam logic [15:0] CRC_INIT  = 16'h0000;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_e;
    function automatic logic [15:0] crc16(input logic [PAYLOAD_W-1:0] d);
        logic [15:0] c;
        c = CRC_INIT;
        for (int i = PAYLOAD_W - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/pack_tx_sched_data_pack.sv
// Data_pack: combinational packer producing {start symbol, payload, CRC16(payload)}.
module Data_pack
    import pack_tx_sched_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] data,
    output logic [PKT_W-1:0]     pkt
);
    assign pkt = {START_SYM, data, crc16(data)};
endmodule

// File: rtl/pack_tx_sched.sv
// pack_tx_sched: two-requester packet scheduler streaming 131-byte packets MSB-first.
// Define PACK_RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module pack_tx_sched
    import pack_tx_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [PAYLOAD_W-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [PAYLOAD_W-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_byte,
    input  logic                 tx_ready,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic                 grant_id,
    output logic                 busy
);
    localparam int         GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [7:0] LAST = 8'(PKT_BYTES - 1);

    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic [PKT_W-1:0]     pkt_q, pkt_d, pkt_w;
    logic [7:0]           cnt_q, cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 grant_q, grant_d;
    logic                 sel;

    Data_pack u_pack (.data(data_q), .pkt(pkt_w));

`ifdef PACK_RR_ARB_EN
    logic rr_q, rr_d;
    // rr_q set means requester 1 wins the next tie
    always_comb begin
        rr_d = (req0_ready | req1_ready) ? req0_ready : rr_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
    assign sel = req1_valid & (~req0_valid | rr_q);
`else
    assign sel = req1_valid & ~req0_valid;
`endif

    assign tx_valid = (state_q == SEND);
    assign tx_byte  = tx_valid ? pkt_q[PKT_W-1 -: 8] : 8'h00;
    assign tx_sop   = tx_valid && (cnt_q == 8'd0);
    assign tx_eop   = tx_valid && (cnt_q == LAST);
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        grant_d    = grant_q;
        pkt_d      = pkt_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: if (!reset && (req0_valid || req1_valid)) begin
                req0_ready = ~sel;
                req1_ready = sel;
                data_d     = sel ? req1_data : req0_data;
                grant_d    = sel;
                state_d    = LOAD;
            end
            LOAD: begin
                pkt_d   = pkt_w;
                cnt_d   = 8'd0;
                gap_d   = '0;
                state_d = SEND;
            end
            SEND: if (tx_ready) begin
                pkt_d = pkt_q << 8;
                cnt_d = cnt_q + 8'd1;
                if (tx_eop) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                gap_d   = (int'(gap_q) == GAP_CYCLES - 1) ? '0 : gap_q + GW'(1);
                state_d = (int'(gap_q) == GAP_CYCLES - 1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            grant_q <= 1'b0;
            pkt_q   <= '0;
            cnt_q   <= 8'd0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_pack_tx_sched.sv
// tb_pack_tx_sched: directed self-checking bench for pack_tx_sched (GAP_CYCLES=2).
// Expected arbitration follows PACK_RR_ARB_EN when the bench is built with it.
module tb_pack_tx_sched;
    logic          clk = 1'b0, reset = 1'b1, tx_ready = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1023:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, tx_valid, tx_sop, tx_eop, grant_id, busy;
    logic [7:0]    tx_byte;
    int            total = 0, bad = 0;

    logic [7:0] rx_b [131];
    logic       rx_sop [131];
    logic       rx_eop [131];
    int         rx_n, rx_hold_err, rx_first;

`ifdef PACK_RR_ARB_EN
    localparam int EXP2 = 1;
`else
    localparam int EXP2 = 0;
`endif

    always #5 clk = ~clk;

    pack_tx_sched #(.GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .grant_id(grant_id), .busy(busy)
    );

    // Bytewise CRC-16 (poly 0x1021, init 0) reference
    function automatic logic [15:0] crc_ref(input logic [1023:0] d);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 127; i >= 0; i--) begin
            c = c ^ {d[i*8 +: 8], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [1023:0] d, input int k);
        logic [1047:0] p;
        p = {8'h3C, d, crc_ref(d)};
        return p[1047 - 8*k -: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20 && busy; c++) step();
    endtask

    task automatic wait_accept(output int who, output bit both);
        who = -1;
        both = 1'b0;
        for (int c = 0; c < 50 && who < 0; c++) begin
            #1;
            both = req0_ready & req1_ready;
            if (req0_ready) who = 0;
            else if (req1_ready) who = 1;
            if (who < 0) step();
        end
    endtask

    // Record every handshaken byte; note any output change while stalled
    task automatic collect(input bit stall);
        logic [9:0] prev;
        logic       pv, pr;
        rx_n = 0; rx_hold_err = 0; rx_first = -1; pv = 1'b0; pr = 1'b1; prev = '0;
        for (int c = 0; c < 2000 && rx_n < 131; c++) begin
            tx_ready = !(stall && (c % 2 == 1));
            #1;
            if (pv && !pr && ({tx_byte, tx_sop, tx_eop} !== prev)) rx_hold_err++;
            if (tx_valid && rx_first < 0) rx_first = c;
            if (tx_valid && tx_ready) begin
                rx_b[rx_n] = tx_byte; rx_sop[rx_n] = tx_sop; rx_eop[rx_n] = tx_eop;
                rx_n++;
            end
            pv = tx_valid; pr = tx_ready; prev = {tx_byte, tx_sop, tx_eop};
            step();
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        total++;
        if ({tx_valid, tx_sop, tx_eop, busy, grant_id, req0_ready, req1_ready, tx_byte} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {tx_valid, tx_sop, tx_eop, busy, grant_id, req0_ready, req1_ready, tx_byte});
        end
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
        step();
    endtask

    task automatic test_zero_packet();
        req0_data = '0; req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL zero_accept got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        #1;
        total++;
        if ({req0_ready, busy, tx_valid, grant_id} !== 4'b0100) begin
            bad++; $display("FAIL zero_load got=%b want=0100", {req0_ready, busy, tx_valid, grant_id});
        end
        collect(1'b0);
        total++;
        if (rx_n !== 131 || rx_first !== 1) begin
            bad++; $display("FAIL zero_count_latency got=%0d/%0d want=131/1", rx_n, rx_first);
        end
        for (int k = 0; k < 131; k++) begin
            total++;
            if (rx_b[k] !== exp_byte(req0_data, k) || rx_sop[k] !== (k == 0) || rx_eop[k] !== (k == 130)) begin
                bad++;
                $display("FAIL zero_byte%0d got=%h/%b%b want=%h/%b%b", k, rx_b[k], rx_sop[k], rx_eop[k],
                         exp_byte(req0_data, k), k == 0, k == 130);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  who, g, ready_at;
        bit  both, gap_busy;
        wait_idle();
        req0_data = {32{32'hDEADBEEF}}; req0_valid = 1'b1;
        wait_accept(who, both);
        step();
        req0_valid = 1'b0;
        collect(1'b0);
        req1_data = {16{64'h0123456789ABCDEF}}; req1_valid = 1'b1;
        ready_at = -1; g = 0; gap_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tx_valid) break;
            if (g == 0) gap_busy = busy;
            if (req1_ready && ready_at < 0) ready_at = g;
            step();
            if (ready_at >= 0) req1_valid = 1'b0;
            g++;
        end
        total++;
        if (g !== 4 || ready_at !== 2 || gap_busy !== 1'b1) begin
            bad++; $display("FAIL b2b_gap got=%0d/%0d/%b want=4/2/1", g, ready_at, gap_busy);
        end
        collect(1'b0);
        total++;
        if (rx_n !== 131 || grant_id !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%0d/%b want=131/1", rx_n, grant_id);
        end
        for (int k = 0; k < 131; k++) begin
            total++;
            if (rx_b[k] !== exp_byte(req1_data, k) || rx_sop[k] !== (k == 0) || rx_eop[k] !== (k == 130)) begin
                bad++;
                $display("FAIL b2b_byte%0d got=%h/%b%b want=%h/%b%b", k, rx_b[k], rx_sop[k], rx_eop[k],
                         exp_byte(req1_data, k), k == 0, k == 130);
            end
        end
    endtask

    task automatic test_stall();
        int who;
        bit both;
        wait_idle();
        req1_data = {128{8'hA5}}; req1_valid = 1'b1;
        wait_accept(who, both);
        total++;
        if (who !== 1) begin bad++; $display("FAIL stall_accept got=%0d want=1", who); end
        step();
        req1_valid = 1'b0;
        collect(1'b1);
        total++;
        if (rx_n !== 131 || rx_hold_err !== 0) begin
            bad++; $display("FAIL stall_hold got=%0d/%0d want=131/0", rx_n, rx_hold_err);
        end
        for (int k = 0; k < 131; k++) begin
            total++;
            if (rx_b[k] !== exp_byte(req1_data, k) || rx_sop[k] !== (k == 0) || rx_eop[k] !== (k == 130)) begin
                bad++;
                $display("FAIL stall_byte%0d got=%h/%b%b want=%h/%b%b", k, rx_b[k], rx_sop[k], rx_eop[k],
                         exp_byte(req1_data, k), k == 0, k == 130);
            end
        end
    endtask

    task automatic test_arbitration();
        int who;
        bit both;
        logic [1023:0] exp_d;
        wait_idle();
        req0_data = {128{8'h5A}}; req1_data = {128{8'hC3}};
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_accept(who, both);
        total++;
        if (who !== 0 || both !== 1'b0) begin bad++; $display("FAIL arb_first got=%0d/%b want=0/0", who, both); end
        step();
        total++;
        if (grant_id !== 1'b0) begin bad++; $display("FAIL arb_grant1 got=%b want=0", grant_id); end
        collect(1'b0);
        total++;
        if (rx_n !== 131 || rx_b[1] !== 8'h5A) begin
            bad++; $display("FAIL arb_pkt1 got=%0d/%h want=131/5a", rx_n, rx_b[1]);
        end
        wait_accept(who, both);
        total++;
        if (who !== EXP2 || both !== 1'b0) begin bad++; $display("FAIL arb_second got=%0d/%b want=%0d/0", who, both, EXP2); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_d = (EXP2 == 1) ? req1_data : req0_data;
        collect(1'b0);
        total++;
        if (rx_n !== 131 || rx_b[1] !== exp_d[1023 -: 8] || grant_id !== 1'(EXP2)) begin
            bad++; $display("FAIL arb_pkt2 got=%0d/%h/%b want=131/%h/%0d", rx_n, rx_b[1], grant_id, exp_d[1023 -: 8], EXP2);
        end
    endtask

    task automatic test_reset_mid();
        int who, stray;
        bit both;
        wait_idle();
        for (int i = 0; i < 128; i++) req0_data[1023 - 8*i -: 8] = 8'(i);
        req0_valid = 1'b1;
        wait_accept(who, both);
        step();
        req0_valid = 1'b0;
        repeat (51) step();
        total++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'h31) begin
            bad++; $display("FAIL mid_byte50 got=%b/%h want=1/31", tx_valid, tx_byte);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({tx_valid, busy, tx_eop, tx_sop} !== 4'b0000) begin
            bad++; $display("FAIL mid_async got=%b want=0000", {tx_valid, busy, tx_eop, tx_sop});
        end
        step(); step();
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (tx_valid || tx_eop || busy) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL mid_no_resend got=%0d want=0", stray); end
        req1_data = {128{8'hF0}}; req1_valid = 1'b1;
        wait_accept(who, both);
        total++;
        if (who !== 1) begin bad++; $display("FAIL mid_accept got=%0d want=1", who); end
        step();
        req1_valid = 1'b0;
        collect(1'b0);
        total++;
        if (rx_n !== 131 || rx_first !== 1 || rx_sop[0] !== 1'b1 || rx_b[0] !== 8'h3C || rx_eop[130] !== 1'b1) begin
            bad++; $display("FAIL mid_restart got=%0d/%0d/%b/%h/%b want=131/1/1/3c/1", rx_n, rx_first, rx_sop[0], rx_b[0], rx_eop[130]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_packet();
        test_back_to_back();
        test_stall();
        test_arbitration();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
